demux_1x2_stream: RTL and testbench

DEMUX_1X2_STREAM -- requirements
Module: demux_1x2_stream

---
 rtl/demux_1x2_stream.sv | 89 ++++++++
 tb/tb_demux_1x2_stream.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_1x2_stream.sv
// Stream demultiplexer: each accepted beat goes to out0 or out1 through a 2-entry skid FIFO.
// Define DEMUX_CNT_EN to add the cnt0/cnt1 delivered-beat counters.
module demux_1x2_stream #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         in_sel,
    output logic         out0_valid,
    input  logic         out0_ready,
    output logic [W-1:0] out0_data,
    output logic         out1_valid,
    input  logic         out1_ready,
    output logic [W-1:0] out1_data
`ifdef DEMUX_CNT_EN
    ,
    output logic [15:0]  cnt0,
    output logic [15:0]  cnt1
`endif
);

    logic [1:0][1:0][W-1:0] mem;
    logic [1:0]             rd_ptr;
    logic [1:0]             wr_ptr;
    logic [1:0]             count [2];
    logic [1:0]             push;
    logic [1:0]             pop;
    logic [1:0]             has_room;

    // A full FIFO still has room when its head leaves this cycle, so only the selected FIFO gates in_ready.
    always_comb begin
        out0_valid  = !rst && (count[0] != 2'd0);
        out1_valid  = !rst && (count[1] != 2'd0);
        out0_data   = mem[0][rd_ptr[0]];
        out1_data   = mem[1][rd_ptr[1]];
        pop[0]      = out0_valid && out0_ready;
        pop[1]      = out1_valid && out1_ready;
        has_room[0] = (count[0] != 2'd2) || pop[0];
        has_room[1] = (count[1] != 2'd2) || pop[1];
        in_ready    = !rst && (in_sel ? has_room[1] : has_room[0]);
        push[0]     = in_valid && in_ready && !in_sel;
        push[1]     = in_valid && in_ready && in_sel;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            for (int p = 0; p < 2; p++) begin
                count[p] <= 2'd0;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (push[p]) begin
                    mem[p][wr_ptr[p]] <= in_data;
                    wr_ptr[p]         <= ~wr_ptr[p];
                end
                if (pop[p]) begin
                    rd_ptr[p] <= ~rd_ptr[p];
                end
                if (push[p] && !pop[p]) begin
                    count[p] <= count[p] + 2'd1;
                end else if (pop[p] && !push[p]) begin
                    count[p] <= count[p] - 2'd1;
                end
            end
        end
    end

`ifdef DEMUX_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt0 <= 16'd0;
            cnt1 <= 16'd0;
        end else begin
            if (pop[0]) begin
                cnt0 <= cnt0 + 16'd1;
            end
            if (pop[1]) begin
                cnt1 <= cnt1 + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_demux_1x2_stream.sv
// Scoreboard bench for demux_1x2_stream: per-output expected queues filled on acceptance, drained by a negedge monitor.
// Define DEMUX_CNT_EN to also check the delivered-beat counters and their wrap.
module tb_demux_1x2_stream;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_sel = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         out0_ready = 1'b0;
    logic         out1_ready = 1'b0;
    logic         in_ready;
    logic         out0_valid;
    logic         out1_valid;
    logic [W-1:0] out0_data;
    logic [W-1:0] out1_data;
`ifdef DEMUX_CNT_EN
    logic [15:0]  cnt0;
    logic [15:0]  cnt1;
`endif

    demux_1x2_stream #(.W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_data  (out0_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data)
`ifdef DEMUX_CNT_EN
        ,
        .cnt0       (cnt0),
        .cnt1       (cnt1)
`endif
    );

    always #5 clk = ~clk;

    int           checkCount = 0;
    int           passCount = 0;
    int           cycle = 0;
    int           del0 = 0;
    int           del1 = 0;
    logic [15:0]  mcnt0 = 16'd0;
    logic [15:0]  mcnt1 = 16'd0;
    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];

    always @(posedge clk) cycle++;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cycle, actual, expected);
        end
    endtask

    // Reference model: a beat is owed to an output from the edge it is accepted until the edge it is taken.
    always @(negedge clk) begin : monitor
        logic expReady;
        if (rst) begin
            checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
            checkOutput("rst_out0_valid", 64'(out0_valid), 64'd0);
            checkOutput("rst_out1_valid", 64'(out1_valid), 64'd0);
            q0.delete();
            q1.delete();
            mcnt0 = 16'd0;
            mcnt1 = 16'd0;
        end else begin
            expReady = in_sel ? (q1.size() < 2 || out1_ready) : (q0.size() < 2 || out0_ready);
            checkOutput("in_ready", 64'(in_ready), 64'(expReady));
            checkOutput("out0_valid", 64'(out0_valid), 64'(q0.size() != 0));
            checkOutput("out1_valid", 64'(out1_valid), 64'(q1.size() != 0));
            if (q0.size() != 0) checkOutput("out0_data", 64'(out0_data), 64'(q0[0]));
            if (q1.size() != 0) checkOutput("out1_data", 64'(out1_data), 64'(q1[0]));
`ifdef DEMUX_CNT_EN
            checkOutput("cnt0", 64'(cnt0), 64'(mcnt0));
            checkOutput("cnt1", 64'(cnt1), 64'(mcnt1));
`endif
            if (q0.size() != 0 && out0_ready) begin
                void'(q0.pop_front());
                del0++;
                mcnt0 = mcnt0 + 16'd1;
            end
            if (q1.size() != 0 && out1_ready) begin
                void'(q1.pop_front());
                del1++;
                mcnt1 = mcnt1 + 16'd1;
            end
            if (in_valid && expReady) begin
                if (in_sel) q1.push_back(in_data);
                else        q0.push_back(in_data);
            end
        end
    end

    // Holds one beat on the input until the DUT takes it, then parks the input with junk payload.
    task automatic applyStimulus(input logic [W-1:0] d, input logic s, input int maxWait);
        int  waitCycles = 0;
        bit  done = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_sel   = s;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                done = 1;
            end else if (waitCycles >= maxWait) begin
                checkCount++;
                $display("[TB] FAIL accept_timeout at cycle %0d: beat %0h sel %0d not accepted within %0d cycles",
                         cycle, d, s, maxWait);
                done = 1;
            end
            waitCycles++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        in_sel   = 1'($urandom);
    endtask

    task automatic waitDrain(input int maxCycles);
        int n = 0;
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        while ((q0.size() != 0 || q1.size() != 0) && n < maxCycles) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (q0.size() != 0 || q1.size() != 0) begin
            checkCount++;
            $display("[TB] FAIL drain_timeout at cycle %0d: %0d/%0d beats still owed", cycle, q0.size(), q1.size());
        end
    endtask

    initial begin : stimulus
        int startCycle;
        int d0;
        int d1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] single routing");
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        applyStimulus(8'hA5, 1'b0, 0);
        applyStimulus(8'h3C, 1'b1, 0);
        waitDrain(20);

        $display("[TB] backpressure");
        out0_ready = 1'b0;
        applyStimulus(8'h01, 1'b0, 0);
        applyStimulus(8'h02, 1'b0, 0);
        in_valid = 1'b1;
        in_data  = 8'h03;
        in_sel   = 1'b0;
        @(negedge clk);
        checkOutput("bp_third_blocked", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        out0_ready = 1'b1;
        applyStimulus(8'h03, 1'b0, 0);
        waitDrain(20);

        $display("[TB] isolation");
        out0_ready = 1'b0;
        out1_ready = 1'b1;
        applyStimulus(8'h11, 1'b0, 0);
        applyStimulus(8'h22, 1'b0, 0);
        applyStimulus(8'h77, 1'b1, 0);
        repeat (3) @(posedge clk);
        #1;
        waitDrain(20);

        $display("[TB] throughput");
        d0 = del0;
        d1 = del1;
        startCycle = cycle;
        for (int i = 0; i < 100; i++) begin
            applyStimulus(8'($urandom), 1'(i % 2), 0);
        end
        checkOutput("thru_cycles", 64'(cycle - startCycle), 64'd100);
        waitDrain(20);
        checkOutput("thru_out0_beats", 64'(del0 - d0), 64'd50);
        checkOutput("thru_out1_beats", 64'(del1 - d1), 64'd50);

        $display("[TB] random traffic");
        for (int i = 0; i < 2000; i++) begin
            in_valid   = 1'($urandom);
            in_data    = 8'($urandom);
            in_sel     = 1'($urandom);
            out0_ready = ($urandom_range(3) != 0);
            out1_ready = ($urandom_range(3) == 0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        waitDrain(50);

        $display("[TB] reset mid-traffic");
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        applyStimulus(8'hC0, 1'b0, 0);
        applyStimulus(8'hC1, 1'b0, 0);
        applyStimulus(8'hD0, 1'b1, 0);
        applyStimulus(8'hD1, 1'b1, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_out0_valid", 64'(out0_valid), 64'd0);
        checkOutput("post_rst_out1_valid", 64'(out1_valid), 64'd0);
        @(posedge clk);
        #1;
        out0_ready = 1'b1;
        d0 = del0;
        applyStimulus(8'h5A, 1'b0, 0);
        waitDrain(20);
        checkOutput("post_rst_delivered", 64'(del0 - d0), 64'd1);

`ifdef DEMUX_CNT_EN
        $display("[TB] counter wrap");
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        in_valid   = 1'b1;
        in_sel     = 1'b0;
        for (int i = 0; i < 65537; i++) begin
            in_data = 8'(i);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        waitDrain(20);
        @(negedge clk);
        checkOutput("wrap_cnt0", 64'(cnt0), 64'd1);
        checkOutput("wrap_cnt1", 64'(cnt1), 64'd0);
`endif

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
